// File: rtl/code_sequencer.sv
// code_sequencer: prescaled 3-bit up/down/ping-pong/hold code counter with step and wrap pulses
module code_sequencer #(
  parameter int PRESCALE = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] code,
  output logic       step,
  output logic       wrap,
  output logic       dir
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, PING = 2'b10, HOLD = 2'b11;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [2:0]    nxt_code;
  logic          nxt_dir;
  logic          nxt_wrap;
  assign tick = en && cnt == LAST;
  // Ping-pong bounces at the ends instead of wrapping.
  always_comb begin
    nxt_code = mode == UP   ? code + 3'd1 :
               mode == DOWN ? code - 3'd1 :
               mode == PING ? (dir ? (code == 3'd0 ? 3'd1 : code - 3'd1)
                                   : (code == 3'd7 ? 3'd6 : code + 3'd1)) :
               code;
    nxt_dir  = mode == UP   ? 1'b0 :
               mode == DOWN ? 1'b1 :
               mode == PING ? (dir ? code != 3'd0 : code == 3'd7) :
               dir;
    nxt_wrap = (mode == UP && code == 3'd7) || (mode == DOWN && code == 3'd0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      code <= 3'd0;
      dir  <= 1'b0;
      step <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      code <= load_val;
      step <= 1'b0;
      wrap <= 1'b0;
    end else begin
      step <= tick && mode != HOLD;
      wrap <= tick && nxt_wrap;
      if (en) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        code <= nxt_code;
        dir  <= nxt_dir;
      end
    end
  end
endmodule

// File: tb/tb_code_sequencer.sv
// tb_code_sequencer: directed checks of code_sequencer with PRESCALE 1, 2 and 4
module tb_code_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic [2:0] code1, code2, code4;
  logic       step1, step2, step4, wrap1, wrap2, wrap4, dir1, dir2, dir4;
  int checks = 0;
  int errors = 0;

  code_sequencer #(.PRESCALE(1)) u1 (.clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .code(code1), .step(step1), .wrap(wrap1), .dir(dir1));
  code_sequencer #(.PRESCALE(2)) u2 (.clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .code(code2), .step(step2), .wrap(wrap2), .dir(dir2));
  code_sequencer #(.PRESCALE(4)) u4 (.clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .code(code4), .step(step4), .wrap(wrap4), .dir(dir4));

  always #5 clk = ~clk;

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    en = 1'b0;
    load = 1'b0;
    mode = 2'b00;
    rst = 1'b1;
    go(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1;
    rst = 1'b1;
    go(3);
    checks++;
    if ({code1, code2, code4} !== 9'd0 || {step1, step2, step4, wrap1, wrap2, wrap4, dir1, dir2, dir4} !== 9'd0) begin
      errors++;
      $display("FAIL reset: codes %0d %0d %0d flags %b%b%b%b%b%b%b%b%b expected all 0", code1, code2, code4,
        step1, step2, step4, wrap1, wrap2, wrap4, dir1, dir2, dir4);
    end
    rst = 1'b0;
  endtask

  task automatic test_up();
    int ec;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      go(1);
      ec = (i / 2) % 8;
      checks++;
      if (code2 !== ec[2:0] || step2 !== (i % 2 == 0) || wrap2 !== (i == 16) || dir2 !== 1'b0) begin
        errors++;
        $display("FAIL up cycle %0d: code %0d step %b wrap %b dir %b expected code %0d step %b wrap %b dir 0",
          i, code2, step2, wrap2, dir2, ec, i % 2 == 0, i == 16);
      end
    end
  endtask

  task automatic test_pingpong();
    int exp_c[11] = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int exp_d[11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    do_reset();
    load = 1'b1;
    load_val = 3'd5;
    go(1);
    load = 1'b0;
    checks++;
    if (code1 !== 3'd5 || step1 !== 1'b0) begin
      errors++;
      $display("FAIL pp_load: code %0d step %b expected code 5 step 0", code1, step1);
    end
    mode = 2'b10;
    en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      go(1);
      checks++;
      if (code1 !== exp_c[i][2:0] || dir1 !== exp_d[i][0] || step1 !== 1'b1 || wrap1 !== 1'b0) begin
        errors++;
        $display("FAIL pingpong step %0d: code %0d dir %b step %b wrap %b expected code %0d dir %0d step 1 wrap 0",
          i, code1, dir1, step1, wrap1, exp_c[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_en_freeze();
    do_reset();
    mode = 2'b01;
    en = 1'b1;
    go(2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      go(1);
      checks++;
      if (code4 !== 3'd0 || step4 !== 1'b0) begin
        errors++;
        $display("FAIL freeze %0d: code %0d step %b expected code 0 step 0", i, code4, step4);
      end
    end
    en = 1'b1;
    go(1);
    checks++;
    if (code4 !== 3'd0 || step4 !== 1'b0) begin
      errors++;
      $display("FAIL resume_early: code %0d step %b expected code 0 step 0", code4, step4);
    end
    go(1);
    checks++;
    if (code4 !== 3'd7 || step4 !== 1'b1 || wrap4 !== 1'b1 || dir4 !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: code %0d step %b wrap %b dir %b expected code 7 step 1 wrap 1 dir 1",
        code4, step4, wrap4, dir4);
    end
    mode = 2'b00;
    go(3);
    checks++;
    if (code4 !== 3'd7 || step4 !== 1'b0 || dir4 !== 1'b1) begin
      errors++;
      $display("FAIL up_pending: code %0d step %b dir %b expected code 7 step 0 dir 1", code4, step4, dir4);
    end
    go(1);
    checks++;
    if (code4 !== 3'd0 || step4 !== 1'b1 || wrap4 !== 1'b1 || dir4 !== 1'b0) begin
      errors++;
      $display("FAIL up_wrap: code %0d step %b wrap %b dir %b expected code 0 step 1 wrap 1 dir 0",
        code4, step4, wrap4, dir4);
    end
  endtask

  task automatic test_load_tick();
    do_reset();
    en = 1'b1;
    go(1);
    load = 1'b1;
    load_val = 3'd3;
    go(1);
    load = 1'b0;
    checks++;
    if (code2 !== 3'd3 || step2 !== 1'b0 || wrap2 !== 1'b0) begin
      errors++;
      $display("FAIL load_prio: code %0d step %b wrap %b expected code 3 step 0 wrap 0", code2, step2, wrap2);
    end
    go(1);
    checks++;
    if (code2 !== 3'd3 || step2 !== 1'b0) begin
      errors++;
      $display("FAIL load_restart: code %0d step %b expected code 3 step 0", code2, step2);
    end
    go(1);
    checks++;
    if (code2 !== 3'd4 || step2 !== 1'b1) begin
      errors++;
      $display("FAIL load_next: code %0d step %b expected code 4 step 1", code2, step2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    go(13);
    checks++;
    if (code2 !== 3'd6) begin
      errors++;
      $display("FAIL pre_rst: code %0d expected 6", code2);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (code2 !== 3'd0 || step2 !== 1'b0 || dir2 !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: code %0d step %b dir %b expected code 0 step 0 dir 0", code2, step2, dir2);
    end
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (code2 !== 3'd0 || step2 !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard: code %0d step %b expected code 0 step 0", code2, step2);
    end
    go(1);
    checks++;
    if (code2 !== 3'd1 || step2 !== 1'b1) begin
      errors++;
      $display("FAIL rst_first_tick: code %0d step %b expected code 1 step 1", code2, step2);
    end
  endtask

  task automatic test_hold_then_up();
    do_reset();
    mode = 2'b11;
    en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      go(1);
      checks++;
      if (code4 !== 3'd0 || step4 !== 1'b0 || wrap4 !== 1'b0) begin
        errors++;
        $display("FAIL hold %0d: code %0d step %b wrap %b expected code 0 step 0 wrap 0", i, code4, step4, wrap4);
      end
    end
    mode = 2'b00;
    go(3);
    checks++;
    if (code4 !== 3'd0 || step4 !== 1'b0) begin
      errors++;
      $display("FAIL hold_to_up_wait: code %0d step %b expected code 0 step 0", code4, step4);
    end
    go(1);
    checks++;
    if (code4 !== 3'd1 || step4 !== 1'b1) begin
      errors++;
      $display("FAIL hold_to_up: code %0d step %b expected code 1 step 1", code4, step4);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_up();
    test_pingpong();
    test_en_freeze();
    test_load_tick();
    test_async_reset();
    test_hold_then_up();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
